// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/owner encodings and default widths for the dmem port arbiter.
package dmem_arb_pkg;
    localparam int ADDR_W_DEF   = 12;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;
    localparam int CNT_W        = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_H = 1'b1;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: fixed-priority P/H winner select with a saturating starvation counter
// that forces an H grant after MAX_WAIT consecutive losses.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic p_req,
    input  logic h_req,
    input  logic arb_en,
    input  logic grant_owner,
    output logic winner
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             starved;

    assign starved = cnt_q == CNT_W'(MAX_WAIT);
    assign winner  = h_req & (~p_req | starved);

    // Counter only moves on arbitration cycles; an H grant or an idle H line clears it.
    always_comb
        cnt_d = !arb_en                            ? cnt_q :
                (!h_req || grant_owner == OWN_H)   ? '0 :
                starved                            ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clock or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares a one-cycle-read single-port dmem between processor (P) and
// host (H) using fixed four-cycle IDLE/ISSUE/WAIT/RESP transactions.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_ack,
    output logic [DATA_W-1:0] p_q,
    input  logic              h_req,
    input  logic              h_wren,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_data,
    output logic              h_ack,
    output logic [DATA_W-1:0] h_q,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              owner
);
    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, pq_q, hq_q;
    logic              wren_q, mem_wren_q, p_ack_q, h_ack_q, busy_q, owner_q;
    logic              winner;

    dmem_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
        .clock       (clock),
        .reset       (reset),
        .p_req       (p_req),
        .h_req       (h_req),
        .arb_en      (state_q == IDLE),
        .grant_owner (winner),
        .winner      (winner)
    );

    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_wren    = mem_wren_q;
    assign p_ack       = p_ack_q;
    assign h_ack       = h_ack_q;
    assign p_q         = pq_q;
    assign h_q         = hq_q;
    assign busy        = busy_q;
    assign owner       = owner_q;

    // Outputs are registered: each is set on the edge entering the state it belongs to.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            mem_wren_q <= 1'b0;
            p_ack_q    <= 1'b0;
            h_ack_q    <= 1'b0;
            pq_q       <= '0;
            hq_q       <= '0;
            busy_q     <= 1'b0;
            owner_q    <= OWN_P;
        end else begin
            p_ack_q    <= 1'b0;
            h_ack_q    <= 1'b0;
            mem_wren_q <= 1'b0;
            case (state_q)
                IDLE:
                    if (p_req || h_req) begin
                        owner_q    <= winner;
                        addr_q     <= winner ? h_addr : p_addr;
                        data_q     <= winner ? h_data : p_data;
                        wren_q     <= winner ? h_wren : p_wren;
                        mem_wren_q <= winner ? h_wren : p_wren;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                ISSUE:
                    state_q <= WAIT;
                WAIT: begin
                    if (!wren_q && owner_q == OWN_H) hq_q <= mem_q;
                    if (!wren_q && owner_q == OWN_P) pq_q <= mem_q;
                    p_ack_q <= owner_q == OWN_P;
                    h_ack_q <= owner_q == OWN_H;
                    state_q <= RESP;
                end
                RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench for the dmem port arbiter with a behavioural dmem.
module tb_dmem_port_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        p_req = 1'b0, p_wren = 1'b0, h_req = 1'b0, h_wren = 1'b0;
    logic [11:0] p_addr = '0, h_addr = '0;
    logic [31:0] p_data = '0, h_data = '0;
    logic        p_ack, h_ack, mem_wren, busy, owner;
    logic [31:0] p_q, h_q, mem_data;
    logic [31:0] mem_q = '0;
    logic [11:0] mem_address;

    typedef struct packed {
        logic        own;
        logic [31:0] q;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [31:0] mem [0:4095];
    logic [31:0] pq_m = '0, hq_m = '0;
    int          n_tests = 0, n_fail = 0, cyc = 0, n_acks = 0, last_ack = -1;
    bit          gap_chk = 1'b0;

    always #5 clock = ~clock;

    dmem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .p_req       (p_req),
        .p_wren      (p_wren),
        .p_addr      (p_addr),
        .p_data      (p_data),
        .p_ack       (p_ack),
        .p_q         (p_q),
        .h_req       (h_req),
        .h_wren      (h_wren),
        .h_addr      (h_addr),
        .h_data      (h_data),
        .h_ack       (h_ack),
        .h_q         (h_q),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .busy        (busy),
        .owner       (owner)
    );

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            mem[12'h7FF] <= 32'h12345678;
            mem[12'h005] <= 32'hA5A5A5A5;
        end else begin
            if (mem_wren) mem[mem_address] <= mem_data;
            mem_q <= mem[mem_address];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock)
        if (!reset && (p_ack || h_ack)) begin
            check("ack_excl", 64'(p_ack & h_ack), 0);
            if (sb.size() == 0) check("sb_unexpected_ack", 1, 0);
            else begin
                e_mon = sb.pop_front();
                check("ack_owner", 64'(h_ack), 64'(e_mon.own));
                check("owner_out", 64'(owner), 64'(e_mon.own));
                check("ack_q", h_ack ? h_q : p_q, 64'(e_mon.q));
            end
            if (gap_chk && last_ack >= 0) check("ack_gap", cyc - last_ack, 4);
            last_ack = cyc;
            n_acks++;
        end

    task automatic push_exp(input bit host, input logic [31:0] q);
        exp_t t;
        t.own = host;
        t.q   = q;
        sb.push_back(t);
    endtask

    task automatic txn(input bit host, input bit wren, input logic [11:0] addr,
                       input logic [31:0] data, input logic [31:0] rd_exp);
        @(negedge clock);
        if (host) begin
            h_req = 1; h_wren = wren; h_addr = addr; h_data = data;
        end else begin
            p_req = 1; p_wren = wren; p_addr = addr; p_data = data;
        end
        if (!wren && host) hq_m = rd_exp;
        if (!wren && !host) pq_m = rd_exp;
        push_exp(host, host ? hq_m : pq_m);
        @(posedge clock); @(negedge clock);
        check("issue_busy", 64'(busy), 1);
        check("issue_wren", 64'(mem_wren), 64'(wren));
        check("issue_addr", 64'(mem_address), 64'(addr));
        if (wren) check("issue_data", 64'(mem_data), 64'(data));
        check("issue_owner", 64'(owner), 64'(host));
        @(posedge clock); @(negedge clock);
        check("wait_wren", 64'(mem_wren), 0);
        check("wait_ack", 64'(p_ack | h_ack), 0);
        @(posedge clock); @(negedge clock);
        check("resp_ack", 64'(host ? h_ack : p_ack), 1);
        check("resp_other_ack", 64'(host ? p_ack : h_ack), 0);
        check("resp_wren", 64'(mem_wren), 0);
        check("other_q", host ? p_q : h_q, host ? pq_m : hq_m);
        if (host) h_req = 0; else p_req = 0;
        @(posedge clock); @(negedge clock);
        check("ack_pulse", 64'(p_ack | h_ack), 0);
        check("idle_busy", 64'(busy), 0);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_p_ack", 64'(p_ack), 0);
        check("rst_h_ack", 64'(h_ack), 0);
        check("rst_mem_wren", 64'(mem_wren), 0);
        check("rst_mem_addr", 64'(mem_address), 0);
        check("rst_mem_data", 64'(mem_data), 0);
        check("rst_p_q", p_q, 0);
        check("rst_h_q", h_q, 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_owner", 64'(owner), 0);
        reset = 0;

        // reset during WAIT of a P read aborts it silently
        @(negedge clock);
        p_req = 1; p_wren = 0; p_addr = 12'h7FF;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        check("mid_pre_busy", 64'(busy), 1);
        reset = 1;
        #1 check("mid_async_busy", 64'(busy), 0);
        @(posedge clock); @(negedge clock);
        check("mid_busy", 64'(busy), 0);
        check("mid_p_ack", 64'(p_ack), 0);
        check("mid_h_ack", 64'(h_ack), 0);
        check("mid_p_q", p_q, 0);
        check("mid_wren", 64'(mem_wren), 0);
        p_req = 0;
        reset = 0;
        repeat (4) @(negedge clock);

        txn(0, 1, 12'h010, 32'hDEADBEEF, 32'h0);
        txn(0, 0, 12'h010, 32'h0, 32'hDEADBEEF);
        txn(1, 0, 12'h7FF, 32'h0, 32'h12345678);

        // simultaneous request: P first, then H
        @(negedge clock);
        p_req = 1; p_wren = 0; p_addr = 12'h010;
        h_req = 1; h_wren = 0; h_addr = 12'h7FF;
        push_exp(0, 32'hDEADBEEF);
        push_exp(1, 32'h12345678);
        @(posedge clock); @(negedge clock);
        check("sim_first_owner", 64'(owner), 0);
        for (int i = 0; i < 10; i++) begin
            if (p_ack) break;
            @(negedge clock);
        end
        check("sim_p_ack", 64'(p_ack), 1);
        p_req = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (h_ack) break;
        end
        check("sim_h_ack", 64'(h_ack), 1);
        h_req = 0;
        repeat (2) @(negedge clock);

        // starvation: both held, grant order P,P,P,P,H twice
        @(negedge clock);
        p_req = 1; p_wren = 0; p_addr = 12'h010;
        h_req = 1; h_wren = 0; h_addr = 12'h7FF;
        for (int k = 0; k < 10; k++) push_exp(k % 5 == 4, (k % 5 == 4) ? 32'h12345678 : 32'hDEADBEEF);
        gap_chk  = 1;
        last_ack = -1;
        base     = n_acks;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            #1;
            if (n_acks - base >= 10) break;
        end
        check("starve_acks", n_acks - base, 10);
        p_req = 0;
        h_req = 0;
        gap_chk = 0;
        repeat (3) @(negedge clock);

        txn(1, 0, 12'h005, 32'h0, 32'hA5A5A5A5);
        txn(1, 1, 12'h005, 32'h00000001, 32'h0);
        check("wr_keeps_h_q", h_q, 32'hA5A5A5A5);
        txn(1, 0, 12'h005, 32'h0, 32'h00000001);
        txn(0, 0, 12'h005, 32'h0, 32'h00000001);

        repeat (3) @(negedge clock);
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end
endmodule
